hazard_controller: RTL and testbench

- Central pipeline control for the 5-stage core.
- Drives stall and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage operand forwarding selects.
- Sequences the data-memory handshake with a small FSM: the EX/MEM register holds until the memory acknowledges.
- Detects load-use hazards and taken-branch redirects.

---
 rtl/hazard_controller_pkg.sv | 22 ++
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/hazard_controller_forward_unit.sv | 22 ++
 rtl/hazard_controller.sv | 133 +++++++++++++
 tb/tb_hazard_controller.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } hz_state_t;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd2;

    function automatic logic is_load(input logic [1:0] wb_sel);
        return wb_sel == WB_LOAD;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle; perf counters exist only with HAZARD_PERF_EN.
interface hazard_controller_if
`ifdef HAZARD_PERF_EN
    #(parameter int XLEN = 32)
`endif
    ;
    logic [4:0] rs1D, rs2D, rs1E, rs2E;
    logic [4:0] waddrE, waddrM, waddrW;
    logic       reg_wrE, reg_wrM, reg_wrW;
    logic [1:0] wb_selE;
    logic       memM;
    logic       dmem_ack;
    logic       br_takenE;

    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushW;
    logic [1:0] fwd_aE, fwd_bE;
    logic       mem_err;
`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] cnt_mem_stall, cnt_load_use, cnt_flush;
`endif

    modport master (
        output rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW,
        output reg_wrE, reg_wrM, reg_wrW, wb_selE, memM, dmem_ack, br_takenE,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  fwd_aE, fwd_bE, mem_err
`ifdef HAZARD_PERF_EN
        , input cnt_mem_stall, cnt_load_use, cnt_flush
`endif
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW,
        input  reg_wrE, reg_wrM, reg_wrW, wb_selE, memM, dmem_ack, br_takenE,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output fwd_aE, fwd_bE, mem_err
`ifdef HAZARD_PERF_EN
        , output cnt_mem_stall, cnt_load_use, cnt_flush
`endif
    );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// EX-stage operand bypass select for one source register; MEM result beats WB result.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] waddrM,
    input  logic [4:0] waddrW,
    input  logic       reg_wrM,
    input  logic       reg_wrW,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_NONE;
        if (reg_wrM && waddrM != '0 && waddrM == rs) begin
            sel = FWD_MEM;
        end else if (reg_wrW && waddrW != '0 && waddrW == rs) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward control with data-memory wait FSM and timeout flag.
// Optional event counters are compiled in with HAZARD_PERF_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int XLEN        = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_controller_if.slave hz
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || XLEN < 1) begin : g_bad_param
        $error("hazard_controller: MEM_TIMEOUT and XLEN must be >= 1");
    end

    hz_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;

    logic     mem_stall, br_flush, load_use_raw, load_use;
    fwd_sel_t fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs      (hz.rs1E),
        .waddrM  (hz.waddrM),
        .waddrW  (hz.waddrW),
        .reg_wrM (hz.reg_wrM),
        .reg_wrW (hz.reg_wrW),
        .sel     (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs      (hz.rs2E),
        .waddrM  (hz.waddrM),
        .waddrW  (hz.waddrW),
        .reg_wrM (hz.reg_wrM),
        .reg_wrW (hz.reg_wrW),
        .sel     (fwd_b)
    );

    // Priority chain: memory stall freezes everything, a branch squashes the load-use victim.
    always_comb begin
        load_use_raw = hz.reg_wrE && is_load(hz.wb_selE) && hz.waddrE != '0 &&
                       (hz.waddrE == hz.rs1D || hz.waddrE == hz.rs2D);
        mem_stall    = !rst && hz.memM && !hz.dmem_ack;
        br_flush     = !rst && !mem_stall && hz.br_takenE;
        load_use     = !rst && !mem_stall && !hz.br_takenE && load_use_raw;
    end

    always_comb begin
        hz.stallF  = mem_stall || load_use;
        hz.stallD  = mem_stall || load_use;
        hz.stallE  = mem_stall;
        hz.stallM  = mem_stall;
        hz.flushD  = br_flush;
        hz.flushE  = br_flush || load_use;
        hz.flushW  = mem_stall;
        hz.fwd_aE  = rst ? FWD_NONE : fwd_a;
        hz.fwd_bE  = rst ? FWD_NONE : fwd_b;
        hz.mem_err = mem_err_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != TIMEOUT_C) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        mem_err_d = mem_err_q || (cnt_d == TIMEOUT_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] cnt_mem_stall_q, cnt_mem_stall_d;
    logic [XLEN-1:0] cnt_load_use_q, cnt_load_use_d;
    logic [XLEN-1:0] cnt_flush_q, cnt_flush_d;

    always_comb begin
        cnt_mem_stall_d = cnt_mem_stall_q + XLEN'(mem_stall);
        cnt_load_use_d  = cnt_load_use_q + XLEN'(load_use);
        cnt_flush_d     = cnt_flush_q + XLEN'(br_flush);
        hz.cnt_mem_stall = cnt_mem_stall_q;
        hz.cnt_load_use  = cnt_load_use_q;
        hz.cnt_flush     = cnt_flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_mem_stall_q <= '0;
            cnt_load_use_q  <= '0;
            cnt_flush_q     <= '0;
        end else begin
            cnt_mem_stall_q <= cnt_mem_stall_d;
            cnt_load_use_q  <= cnt_load_use_d;
            cnt_flush_q     <= cnt_flush_d;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table, multi-cycle sequences, scoreboard queue.
module tb_hazard_controller;
    import hazard_pkg::*;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW;
        logic       reg_wrE, reg_wrM, reg_wrW;
        logic [1:0] wb_selE;
        logic       memM, dmem_ack, br;
    } vec_t;

    typedef struct {
        vec_t        in;
        logic [11:0] exp;
        string       name;
    } tvec_t;

    typedef struct {
        logic [11:0] exp;
        string       name;
    } sb_t;

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushW,fwd_a,fwd_b,mem_err}
    localparam logic [11:0] E_NONE = 12'b0000000_00_00_0;
    localparam logic [11:0] E_LU   = 12'b1100010_00_00_0;
    localparam logic [11:0] E_BR   = 12'b0000110_00_00_0;
    localparam logic [11:0] E_MS   = 12'b1111001_00_00_0;
    localparam logic [11:0] E_ERR  = 12'b0000000_00_00_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    sb_t  sb_q[$];
    tvec_t tab[10];

    hazard_controller_if hz();

    hazard_controller #(.MEM_TIMEOUT(64), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE,
                hz.flushW, hz.fwd_aE, hz.fwd_bE, hz.mem_err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        hz.rs1D      = v.rs1D;
        hz.rs2D      = v.rs2D;
        hz.rs1E      = v.rs1E;
        hz.rs2E      = v.rs2E;
        hz.waddrE    = v.waddrE;
        hz.waddrM    = v.waddrM;
        hz.waddrW    = v.waddrW;
        hz.reg_wrE   = v.reg_wrE;
        hz.reg_wrM   = v.reg_wrM;
        hz.reg_wrW   = v.reg_wrW;
        hz.wb_selE   = v.wb_selE;
        hz.memM      = v.memM;
        hz.dmem_ack  = v.dmem_ack;
        hz.br_takenE = v.br;
    endtask

    // One clock: drive after the edge, queue the expectation, compare mid-cycle.
    task automatic cyc(input vec_t v, input logic [11:0] exp, input string name);
        sb_t e;
        @(posedge clk);
        #1;
        drive(v);
        sb_q.push_back('{exp, name});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check(e.name, {20'd0, outs()}, {20'd0, e.exp});
        end
    endtask

    vec_t v, idle_v, ms_v, lu_v;

    initial begin
        v = '0;
        drive(v);
        rst = 1'b1;

        idle_v = '0;
        ms_v = '0; ms_v.memM = 1'b1;
        lu_v = '0; lu_v.reg_wrE = 1'b1; lu_v.wb_selE = WB_LOAD; lu_v.waddrE = 5'd3; lu_v.rs2D = 5'd3;

        v = '0; v.reg_wrM = 1; v.waddrM = 5; v.rs1E = 5; v.reg_wrW = 1; v.waddrW = 5; v.rs2E = 7;
        tab[0] = '{v, 12'b0000000_10_00_0, "fwd_mem_priority"};
        v.waddrM = 0;
        tab[1] = '{v, 12'b0000000_01_00_0, "fwd_wb"};
        v = '0; v.reg_wrM = 1; v.waddrM = 9; v.rs2E = 9; v.reg_wrW = 1; v.waddrW = 4; v.rs1E = 4;
        tab[2] = '{v, 12'b0000000_01_10_0, "fwd_a_wb_b_mem"};
        v = '0; v.waddrM = 5; v.rs1E = 5; v.waddrW = 5; v.rs2E = 5;
        tab[3] = '{v, E_NONE, "fwd_wr_disabled"};
        tab[4] = '{lu_v, E_LU, "load_use_rs2"};
        v = lu_v; v.waddrE = 0; v.rs2D = 0;
        tab[5] = '{v, E_NONE, "load_use_x0"};
        v = lu_v; v.wb_selE = WB_ALU;
        tab[6] = '{v, E_NONE, "alu_no_stall"};
        v = lu_v; v.br = 1;
        tab[7] = '{v, E_BR, "branch_over_load_use"};
        v = '0; v.memM = 1; v.dmem_ack = 1;
        tab[8] = '{v, E_NONE, "zero_wait_ack"};
        v = '0; v.reg_wrE = 1; v.wb_selE = WB_LOAD; v.waddrE = 12; v.rs1D = 12;
        tab[9] = '{v, E_LU, "load_use_rs1"};

        // Reset state
        @(posedge clk);
        v = '0; v.rst = 1; v.memM = 1; v.br = 1; v.reg_wrM = 1; v.waddrM = 2; v.rs1E = 2;
        cyc(v, E_NONE, "reset_outputs");
        check("reset_state", {31'd0, dut.state_q}, {31'd0, IDLE});

        for (int unsigned i = 0; i < 10; i++) cyc(tab[i].in, tab[i].exp, tab[i].name);

        // Single bubble: the dependent instruction advances, stall must drop
        cyc(lu_v, E_LU, "lu_bubble");
        v = '0; v.rs1E = 3;
        cyc(v, E_NONE, "lu_released");

        // Memory wait of 3 cycles with a branch pending in EX
        v = ms_v; v.br = 1;
        for (int unsigned i = 0; i < 3; i++) cyc(v, E_MS, "mem_wait_stall");
        v.dmem_ack = 1;
        cyc(v, E_BR, "mem_ack_branch_released");
        cyc(idle_v, E_NONE, "after_ack_idle");
        check("state_idle_after_ack", {31'd0, dut.state_q}, {31'd0, IDLE});

        // Reset in the middle of a wait
        cyc(ms_v, E_MS, "midwait_stall0");
        cyc(ms_v, E_MS, "midwait_stall1");
        v = ms_v; v.rst = 1;
        cyc(v, E_NONE, "midwait_reset_drops_stall");
        cyc(idle_v, E_NONE, "midwait_after_reset");
        check("midwait_state_idle", {31'd0, dut.state_q}, {31'd0, IDLE});

        // Timeout: flag rises after 64 stalled cycles and is sticky
        for (int unsigned i = 0; i < 64; i++) cyc(ms_v, E_MS, "timeout_pre");
        cyc(ms_v, E_MS | E_ERR, "timeout_err_set");
        v = ms_v; v.dmem_ack = 1;
        cyc(v, E_ERR, "timeout_err_after_ack");
        cyc(idle_v, E_ERR, "timeout_err_sticky");
        v = '0; v.rst = 1;
        cyc(v, E_ERR, "timeout_err_during_rst");
        cyc(idle_v, E_NONE, "timeout_err_cleared");
        check("timeout_state_idle", {31'd0, dut.state_q}, {31'd0, IDLE});

`ifdef HAZARD_PERF_EN
        cyc(lu_v, E_LU, "perf_lu0");
        cyc(idle_v, E_NONE, "perf_gap");
        cyc(lu_v, E_LU, "perf_lu1");
        for (int unsigned i = 0; i < 4; i++) cyc(ms_v, E_MS, "perf_ms");
        v = ms_v; v.dmem_ack = 1;
        cyc(v, E_NONE, "perf_ack");
        v = '0; v.br = 1;
        cyc(v, E_BR, "perf_br");
        cyc(idle_v, E_NONE, "perf_idle");
        check("cnt_load_use", hz.cnt_load_use, 32'd2);
        check("cnt_mem_stall", hz.cnt_mem_stall, 32'd4);
        check("cnt_flush", hz.cnt_flush, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
